enigma_feeder: RTL and testbench
================================

ENIGMA_FEEDER -- requirements
Module: enigma_feeder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, input FIFO entries (power of two, >=2).
REQ-002 The block SHALL have parameter TIMEOUT, default 256, max cycles waited for core_done.
REQ-003 The block SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port in_valid  input  1  host byte valid.
REQ-006 The block SHALL have port in_data  input  8  host ASCII byte.
REQ-007 The block SHALL have port in_ready  output  1  FIFO can accept; equals not-full.
REQ-008 The block SHALL have port core_valid  output  1  one-cycle start pulse to cipher core.
REQ-009 The block SHALL have port core_din  output  8  letter index 0..25 to core.
REQ-010 The block SHALL have port core_done  input  1  core result-valid pulse.
REQ-011 The block SHALL have port core_dout  input  8  core result index.
REQ-012 The block SHALL have port out_valid  output  1  result byte valid.
REQ-013 The block SHALL have port out_data  output  8  result ASCII byte.
REQ-014 The block SHALL have port out_ready  input  1  downstream accepts.
REQ-015 The block SHALL have port busy  output  1  high in any state other than IDLE.
REQ-016 The block SHALL have port err_timeout  output  1  sticky timeout flag.

Function
REQ-017 The FIFO SHALL push in_data on a cycle with in_valid and in_ready both high; bytes leave in arrival order.
REQ-018 A simultaneous push and pop SHALL leave the occupancy unchanged; read/write pointers wrap modulo DEPTH.
REQ-019 The FSM SHALL have states IDLE, ISSUE, WAIT, OUT.
REQ-020 In IDLE with FIFO non-empty, the FSM SHALL pop the head byte; letter -> ISSUE, non-letter -> OUT; empty FIFO stays IDLE.
REQ-021 Letters SHALL be 8'h41-8'h5A and 8'h61-8'h7A; index = byte-8'h41 or byte-8'h61.
REQ-022 ISSUE SHALL last exactly one cycle with core_valid=1 and core_din=index, then go to WAIT.
REQ-023 core_din SHALL hold the index from ISSUE until the next ISSUE.
REQ-024 In WAIT, core_done SHALL capture core_dout and go to OUT; out_data = 8'h41+core_dout if core_dout<26, else 8'h3F.
REQ-025 core_done SHALL be ignored outside WAIT.
REQ-026 A wait counter SHALL clear on ISSUE and increment each WAIT cycle; after TIMEOUT WAIT cycles without core_done the FSM SHALL set err_timeout, load out_data=8'h3F, and go to OUT.
REQ-027 Non-letter bytes SHALL pass to out_data unchanged, never touching the core.
REQ-028 In OUT, out_valid=1 and out_data SHALL hold stable until out_ready=1, then return to IDLE on that edge.
REQ-029 Minimum letter latency: accepting edge N -> core_valid high in cycle after edge N+1; out_valid in cycle after core_done edge.
REQ-030 At most one byte SHALL be in flight to the core at any time.

Reset
REQ-031 reset_n low SHALL immediately force state IDLE, FIFO empty, pointers 0, in_ready=1, core_valid=0, core_din=0, out_valid=0, out_data=0, busy=0, err_timeout=0, wait counter 0.
REQ-032 Reset mid-WAIT SHALL discard the in-flight byte; a later core_done SHALL be ignored.
REQ-033 err_timeout SHALL clear only by reset.

Verification
REQ-034 Push 'h','I' with core echoing index -> core_din 7 then 8; out_data 'H' then 'I', in order.
REQ-035 Push ' ' between 'A','B' -> core_valid exactly twice; out_data 'A',8'h20,'B'.
REQ-036 Push DEPTH+1 bytes with core never done -> in_ready low after DEPTH accepted while head in flight; after TIMEOUT cycles err_timeout=1, out_data 8'h3F.
REQ-037 Hold out_ready=0 for 10 cycles in OUT -> out_valid and out_data stable, no new core_valid.
REQ-038 core_dout=30 -> out_data 8'h3F, err_timeout stays 0.
REQ-039 Assert reset_n low in WAIT, then pulse core_done -> all outputs at reset values, no out_valid.

Source files
------------

// File: rtl/enigma_feeder.sv
// enigma_feeder: buffers host ASCII bytes in a small FIFO, converts letters
// to 0..25 indices for a single-issue cipher core, and returns the core's
// result (or non-letters unchanged) as ASCII on a valid/ready output.
module enigma_feeder #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 256
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       core_valid,
    output logic [7:0] core_din,
    input  logic       core_done,
    input  logic [7:0] core_dout,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic       busy,
    output logic       err_timeout
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    logic [1:0]    state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [CW-1:0] wait_cnt;

    logic       push;
    logic       pop;
    logic [7:0] head;
    logic       head_upper;
    logic       head_lower;
    logic [7:0] head_index;
    logic [7:0] done_char;

    assign in_ready   = (count != FULL_CNT);
    assign push       = in_valid && in_ready;
    assign pop        = (state == S_IDLE) && (count != '0);
    assign head       = mem[rd_ptr];
    assign head_upper = (head >= 8'h41) && (head <= 8'h5A);
    assign head_lower = (head >= 8'h61) && (head <= 8'h7A);
    assign head_index = head_upper ? (head - 8'h41) : (head - 8'h61);
    assign done_char  = (core_dout < 8'd26) ? (8'h41 + core_dout) : 8'h3F;

    assign core_valid = (state == S_ISSUE);
    assign out_valid  = (state == S_OUT);
    assign busy       = (state != S_IDLE);

    // FIFO storage: written on every accepted host byte, no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH (power of two)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Control FSM: one byte in flight at a time, timeout watchdog while waiting
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            core_din    <= '0;
            out_data    <= '0;
            err_timeout <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (count != '0) begin
                        if (head_upper || head_lower) begin
                            core_din <= head_index;
                            state    <= S_ISSUE;
                        end else begin
                            out_data <= head;
                            state    <= S_OUT;
                        end
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (core_done) begin
                        out_data <= done_char;
                        state    <= S_OUT;
                    end else if (wait_cnt == TO_LAST) begin
                        err_timeout <= 1'b1;
                        out_data    <= 8'h3F;
                        state       <= S_OUT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_OUT: begin
                    if (out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_enigma_feeder.sv
// Directed testbench for enigma_feeder with a small behavioural cipher-core
// responder and monitors that log core issues and accepted output bytes.
module tb_enigma_feeder;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       core_valid;
    logic [7:0] core_din;
    logic       core_done;
    logic [7:0] core_dout;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready = 1'b1;
    logic       busy;
    logic       err_timeout;

    int total = 0;
    int bad = 0;

    logic [7:0] cv_q[$];
    logic [7:0] out_q[$];

    // responder mode: 0 never answers, 1 echoes the index, 2 answers resp_val
    int         resp_mode = 0;
    logic [7:0] resp_val = 8'h00;
    int         manual_req = 0;
    int         manual_done = 0;

    always #5 clk = ~clk;

    enigma_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .core_valid (core_valid),
        .core_din   (core_din),
        .core_done  (core_done),
        .core_dout  (core_dout),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .busy       (busy),
        .err_timeout(err_timeout)
    );

    // log every core issue and every accepted output byte
    always @(negedge clk) begin
        if (reset_n && core_valid) cv_q.push_back(core_din);
        if (reset_n && out_valid && out_ready) out_q.push_back(out_data);
    end

    // cipher core model: answers one cycle after the issue pulse
    initial begin : responder
        logic [7:0] d;
        core_done = 1'b0;
        core_dout = 8'h00;
        forever begin
            @(negedge clk);
            if ((core_valid && resp_mode != 0) || (manual_req != manual_done)) begin
                d = (resp_mode == 1) ? core_din : resp_val;
                manual_done = manual_req;
                @(posedge clk); #1 core_done = 1'b1; core_dout = d;
                @(posedge clk); #1 core_done = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        @(posedge clk); #1 in_valid = 1'b1; in_data = b;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL send_ready byte=%0h got=%b want=1", b, in_ready); end
        @(posedge clk); #1 in_valid = 1'b0;
    endtask

    task automatic wait_outs(input int n);
        int k;
        k = 0;
        while (out_q.size() < n && k < 400) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (out_q.size() < n) begin bad++; $display("FAIL wait_outs got=%0d want=%0d", out_q.size(), n); end
        repeat (2) @(negedge clk);
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
        cv_q.delete();
        out_q.delete();
    endtask

    task automatic test_reset();
        #3 reset_n = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1)    begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (core_valid !== 1'b0)  begin bad++; $display("FAIL reset_core_valid got=%b want=0", core_valid); end
        total++; if (core_din !== 8'h00)   begin bad++; $display("FAIL reset_core_din got=%0h want=0", core_din); end
        total++; if (out_valid !== 1'b0)   begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (out_data !== 8'h00)   begin bad++; $display("FAIL reset_out_data got=%0h want=0", out_data); end
        total++; if (busy !== 1'b0)        begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err_timeout); end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        total++; if (busy !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL reset_release busy=%b in_ready=%b want 0/1", busy, in_ready); end
        settle();
    endtask

    task automatic test_latency();
        resp_mode = 2; resp_val = 8'd5;
        @(posedge clk); #1 in_valid = 1'b1; in_data = 8'h43;
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        total++; if (core_valid !== 1'b0) begin bad++; $display("FAIL lat_early_issue got=%b want=0", core_valid); end
        @(negedge clk);
        total++; if (core_valid !== 1'b1) begin bad++; $display("FAIL lat_issue got=%b want=1", core_valid); end
        total++; if (core_din !== 8'd2)   begin bad++; $display("FAIL lat_din got=%0d want=2", core_din); end
        @(negedge clk);
        total++; if (core_valid !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL lat_wait cv=%b ov=%b want 0/0", core_valid, out_valid); end
        @(negedge clk);
        total++; if (out_valid !== 1'b1)  begin bad++; $display("FAIL lat_out_valid got=%b want=1", out_valid); end
        total++; if (out_data !== 8'h46)  begin bad++; $display("FAIL lat_out_data got=%0h want=46", out_data); end
        total++; if (core_din !== 8'd2)   begin bad++; $display("FAIL lat_din_hold got=%0d want=2", core_din); end
        @(negedge clk);
        total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL lat_done ov=%b busy=%b want 0/0", out_valid, busy); end
        settle();
    endtask

    task automatic test_echo();
        resp_mode = 1;
        send(8'h68);
        send(8'h49);
        wait_outs(2);
        total++; if (cv_q.size() !== 2) begin bad++; $display("FAIL echo_issue_count got=%0d want=2", cv_q.size()); end
        total++; if (cv_q[0] !== 8'd7)   begin bad++; $display("FAIL echo_din0 got=%0d want=7", cv_q[0]); end
        total++; if (cv_q[1] !== 8'd8)   begin bad++; $display("FAIL echo_din1 got=%0d want=8", cv_q[1]); end
        total++; if (out_q[0] !== 8'h48) begin bad++; $display("FAIL echo_out0 got=%0h want=48", out_q[0]); end
        total++; if (out_q[1] !== 8'h49) begin bad++; $display("FAIL echo_out1 got=%0h want=49", out_q[1]); end
        settle();
    endtask

    task automatic test_nonletter();
        logic [7:0] stim [7];
        stim = '{8'h41, 8'h20, 8'h42, 8'h40, 8'h5B, 8'h60, 8'h7B};
        resp_mode = 1;
        for (int i = 0; i < 7; i++) send(stim[i]);
        wait_outs(7);
        total++; if (cv_q.size() !== 2) begin bad++; $display("FAIL nl_issue_count got=%0d want=2", cv_q.size()); end
        total++; if (cv_q[0] !== 8'd0)   begin bad++; $display("FAIL nl_din0 got=%0d want=0", cv_q[0]); end
        total++; if (cv_q[1] !== 8'd1)   begin bad++; $display("FAIL nl_din1 got=%0d want=1", cv_q[1]); end
        for (int i = 0; i < 7; i++) begin
            total++;
            if (out_q[i] !== stim[i]) begin bad++; $display("FAIL nl_out%0d got=%0h want=%0h", i, out_q[i], stim[i]); end
        end
        settle();
    endtask

    task automatic test_index_range();
        logic [7:0] bytes [4];
        logic [7:0] vals  [4];
        logic [7:0] idx   [4];
        logic [7:0] outs  [4];
        bytes = '{8'h7A, 8'h61, 8'h6D, 8'h51};
        vals  = '{8'd30, 8'd25, 8'd26, 8'd0};
        idx   = '{8'd25, 8'd0,  8'd12, 8'd16};
        outs  = '{8'h3F, 8'h5A, 8'h3F, 8'h41};
        resp_mode = 2;
        for (int i = 0; i < 4; i++) begin
            resp_val = vals[i];
            send(bytes[i]);
            wait_outs(1);
            total++; if (cv_q[0] !== idx[i])   begin bad++; $display("FAIL idx_din%0d got=%0d want=%0d", i, cv_q[0], idx[i]); end
            total++; if (out_q[0] !== outs[i]) begin bad++; $display("FAIL idx_out%0d got=%0h want=%0h", i, out_q[0], outs[i]); end
            settle();
        end
        total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL idx_err got=%b want=0", err_timeout); end
    endtask

    task automatic test_hold();
        int k;
        resp_mode = 1;
        out_ready = 1'b0;
        send(8'h6B);
        send(8'h78);
        k = 0;
        @(negedge clk);
        while (!out_valid && k < 100) begin @(negedge clk); k++; end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL hold_reach got=%b want=1", out_valid); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total++; if (out_valid !== 1'b1)  begin bad++; $display("FAIL hold_valid c=%0d got=%b want=1", c, out_valid); end
            total++; if (out_data !== 8'h4B)  begin bad++; $display("FAIL hold_data c=%0d got=%0h want=4b", c, out_data); end
            total++; if (core_valid !== 1'b0) begin bad++; $display("FAIL hold_issue c=%0d got=%b want=0", c, core_valid); end
        end
        @(posedge clk); #1 out_ready = 1'b1;
        wait_outs(2);
        total++; if (out_q[0] !== 8'h4B) begin bad++; $display("FAIL hold_out0 got=%0h want=4b", out_q[0]); end
        total++; if (out_q[1] !== 8'h58) begin bad++; $display("FAIL hold_out1 got=%0h want=58", out_q[1]); end
        settle();
    endtask

    task automatic test_timeout();
        int  acc;
        bit  take;
        resp_mode = 0;
        out_ready = 1'b0;
        acc = 0;
        @(posedge clk); #1 in_valid = 1'b1; in_data = 8'h61;
        for (int c = 0; c <= TIMEOUT + 3; c++) begin
            @(negedge clk);
            take = in_valid && in_ready;
            if (c == 1) begin
                total++; if (core_valid !== 1'b0) begin bad++; $display("FAIL to_early_issue got=%b want=0", core_valid); end
            end
            if (c == 2) begin
                total++; if (core_valid !== 1'b1) begin bad++; $display("FAIL to_issue got=%b want=1", core_valid); end
                total++; if (core_din !== 8'd0)   begin bad++; $display("FAIL to_din got=%0d want=0", core_din); end
            end
            if (c == DEPTH + 1) begin
                total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL to_full got=%b want=0", in_ready); end
            end
            if (c == TIMEOUT + 2) begin
                total++; if (err_timeout !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b1) begin
                    bad++; $display("FAIL to_last_wait err=%b ov=%b busy=%b want 0/0/1", err_timeout, out_valid, busy);
                end
            end
            if (c == TIMEOUT + 3) begin
                total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL to_err got=%b want=1", err_timeout); end
                total++; if (out_valid !== 1'b1)   begin bad++; $display("FAIL to_out_valid got=%b want=1", out_valid); end
                total++; if (out_data !== 8'h3F)   begin bad++; $display("FAIL to_out_data got=%0h want=3f", out_data); end
            end
            @(posedge clk);
            if (take) acc++;
            #1 in_valid = (acc < DEPTH + 1); in_data = 8'h61 + acc[7:0];
        end
        in_valid = 1'b0;
        total++; if (cv_q.size() !== 1) begin bad++; $display("FAIL to_single_issue got=%0d want=1", cv_q.size()); end
        resp_mode = 1;
        out_ready = 1'b1;
        wait_outs(DEPTH + 1);
        total++; if (out_q[0] !== 8'h3F) begin bad++; $display("FAIL to_drain0 got=%0h want=3f", out_q[0]); end
        for (int i = 1; i <= DEPTH; i++) begin
            total++;
            if (out_q[i] !== 8'h41 + 8'(i)) begin bad++; $display("FAIL to_drain%0d got=%0h want=%0h", i, out_q[i], 8'h41 + 8'(i)); end
        end
        total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL to_sticky got=%b want=1", err_timeout); end
        total++; if (in_ready !== 1'b1)    begin bad++; $display("FAIL to_empty got=%b want=1", in_ready); end
        settle();
    endtask

    task automatic test_reset_wait();
        int k;
        resp_mode = 0;
        send(8'h71);
        k = 0;
        @(negedge clk);
        while (!core_valid && k < 50) begin @(negedge clk); k++; end
        total++; if (core_valid !== 1'b1) begin bad++; $display("FAIL rw_issue got=%b want=1", core_valid); end
        @(posedge clk); #2 reset_n = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1)    begin bad++; $display("FAIL rw_in_ready got=%b want=1", in_ready); end
        total++; if (core_valid !== 1'b0)  begin bad++; $display("FAIL rw_core_valid got=%b want=0", core_valid); end
        total++; if (core_din !== 8'h00)   begin bad++; $display("FAIL rw_core_din got=%0h want=0", core_din); end
        total++; if (out_valid !== 1'b0)   begin bad++; $display("FAIL rw_out_valid got=%b want=0", out_valid); end
        total++; if (out_data !== 8'h00)   begin bad++; $display("FAIL rw_out_data got=%0h want=0", out_data); end
        total++; if (busy !== 1'b0)        begin bad++; $display("FAIL rw_busy got=%b want=0", busy); end
        total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL rw_err got=%b want=0", err_timeout); end
        @(posedge clk); #1 reset_n = 1'b1;
        manual_req++;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rw_after c=%0d ov=%b busy=%b want 0/0", c, out_valid, busy); end
        end
        total++; if (out_q.size() !== 0) begin bad++; $display("FAIL rw_no_output got=%0d want=0", out_q.size()); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_echo();
        test_nonletter();
        test_index_range();
        test_hold();
        test_timeout();
        test_reset_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
